// File: rtl/pipe_pkg.sv
// pipe_pkg: FSM encoding and stall-priority depths for the pipeline sequencer
package pipe_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, REDIR = 2'd2} state_t;
  typedef logic [2:0] depth_t;
  localparam depth_t HOLD_NONE = 3'd0;
  localparam depth_t HOLD_PC = 3'd1;
  localparam depth_t HOLD_IF2ID = 3'd2;
  localparam depth_t HOLD_ID2EX = 3'd3;
  localparam depth_t HOLD_EX2MEM = 3'd4;
  // Depth n holds the first n of PC/IF2ID/ID2EX/EX2MEM and bubbles the register right after them
  function automatic depth_t stallDepth(input logic dStall, input logic busy, input logic loadUse, input logic iStall);
    return dStall ? HOLD_EX2MEM : busy ? HOLD_ID2EX : loadUse ? HOLD_IF2ID : iStall ? HOLD_PC : HOLD_NONE;
  endfunction
endpackage

// File: rtl/muldiv_cycle_cnt.sv
// muldiv_cycle_cnt: counts non-DStall cycles a mul/div has spent in E
module muldiv_cycle_cnt #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic MulDivE,
  input  logic DStall,
  input  logic advance,
  input  logic flush,
  output logic busy
);
  logic [CNT_W-1:0] cnt;
  assign busy = MulDivE && cnt < CNT_W'(MULDIV_CYCLES - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (flush || (advance && !busy)) cnt <= '0;
    else if (busy && !DStall) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage pipeline registers and PC
module pipe_ctrl import pipe_pkg::*; #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IStall,
  input  logic        DStall,
  input  logic        LoadUseD,
  input  logic        MulDivE,
  input  logic        ExceptionM,
  input  logic        EretM,
  input  logic [31:0] ExcVector,
  input  logic [31:0] EPC,
  output logic        PCEn,
  output logic        IF2IDEn,
  output logic        IF2IDClr,
  output logic        ID2EXEn,
  output logic        ID2EXClr,
  output logic        EX2MEMEn,
  output logic        EX2MEMClr,
  output logic        MEM2WBEn,
  output logic        MEM2WBClr,
  output logic        RedirectValid,
  output logic [31:0] RedirectPC,
  output logic        MulDivBusy
);
  state_t state;
  logic [31:0] tgt, liveTgt;
  logic busy, ev, flush, run;
  depth_t depth;
  muldiv_cycle_cnt #(.MULDIV_CYCLES(MULDIV_CYCLES), .CNT_W(CNT_W)) cnt (
    .clk(clk), .rst(rst), .MulDivE(MulDivE), .DStall(DStall),
    .advance(EX2MEMEn), .flush(flush), .busy(busy)
  );
  always_comb begin
    ev = ExceptionM || EretM;
    liveTgt = ExceptionM ? ExcVector : EPC;
    flush = rst && (state == REDIR || (state == DRAIN && !DStall) || (state == RUN && ev && !DStall));
    run = rst && state == RUN && !ev;
    depth = stallDepth(DStall, busy, LoadUseD, IStall);
    PCEn = flush || (run && depth == HOLD_NONE);
    IF2IDEn = flush || (run && depth < HOLD_IF2ID);
    IF2IDClr = flush || (run && depth == HOLD_PC);
    ID2EXEn = flush || (run && depth < HOLD_ID2EX);
    ID2EXClr = flush || (run && depth == HOLD_IF2ID);
    EX2MEMEn = flush || (run && depth < HOLD_EX2MEM);
    EX2MEMClr = flush || (run && depth == HOLD_ID2EX);
    MEM2WBEn = flush || run;
    MEM2WBClr = flush || (run && depth == HOLD_EX2MEM);
    RedirectValid = flush;
    RedirectPC = !flush ? '0 : state == RUN ? liveTgt : tgt;
    MulDivBusy = rst && busy;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RUN;
      tgt <= '0;
    end else begin
      if (state == RUN && ev) tgt <= liveTgt;
      state <= flush ? (IStall ? REDIR : RUN) : (state == RUN && ev) ? DRAIN : state;
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a behavioural model
module tb_pipe_ctrl;
  localparam int MD = 4;
  localparam int RUNNING = 0, DRAINING = 1, REDIRECTING = 2;
  logic clk = 0, rstn = 0;
  logic iSt = 0, dSt = 0, lu = 0, md = 0, exc = 0, eret = 0;
  logic [31:0] vec = 0, epc = 0;
  logic PCEn, IF2IDEn, IF2IDClr, ID2EXEn, ID2EXClr, EX2MEMEn, EX2MEMClr, MEM2WBEn, MEM2WBClr;
  logic RedirectValid, MulDivBusy;
  logic [31:0] RedirectPC;
  logic [42:0] outs;
  int total = 0, bad = 0;
  int mode = RUNNING, mdDone = 0;
  logic [31:0] pendPC = 0;

  pipe_ctrl #(.MULDIV_CYCLES(MD), .CNT_W(3)) dut (
    .clk(clk), .rst(rstn), .IStall(iSt), .DStall(dSt), .LoadUseD(lu), .MulDivE(md),
    .ExceptionM(exc), .EretM(eret), .ExcVector(vec), .EPC(epc),
    .PCEn(PCEn), .IF2IDEn(IF2IDEn), .IF2IDClr(IF2IDClr), .ID2EXEn(ID2EXEn), .ID2EXClr(ID2EXClr),
    .EX2MEMEn(EX2MEMEn), .EX2MEMClr(EX2MEMClr), .MEM2WBEn(MEM2WBEn), .MEM2WBClr(MEM2WBClr),
    .RedirectValid(RedirectValid), .RedirectPC(RedirectPC), .MulDivBusy(MulDivBusy)
  );

  assign outs = {PCEn, IF2IDEn, IF2IDClr, ID2EXEn, ID2EXClr, EX2MEMEn, EX2MEMClr,
                 MEM2WBEn, MEM2WBClr, RedirectValid, MulDivBusy, RedirectPC};

  always #5 clk = ~clk;

  // Stage s (0=PC..4=MEM2WB) is held when s < number of held stages; the first free stage takes the bubble
  function automatic logic [42:0] expOut();
    logic [4:0] en, clr;
    logic busy, ev, fl, fr;
    int held;
    logic [31:0] pc;
    if (!rstn) return '0;
    busy = md && mdDone < MD - 1;
    ev = exc || eret;
    fl = (mode == REDIRECTING) || (mode == DRAINING && !dSt) || (mode == RUNNING && ev && !dSt);
    fr = !fl && (mode != RUNNING || ev);
    held = dSt ? 4 : busy ? 3 : lu ? 2 : iSt ? 1 : 0;
    for (int s = 0; s < 5; s++) begin
      en[s] = fl || (!fr && s >= held);
      clr[s] = s > 0 && (fl || (!fr && s == held));
    end
    pc = !fl ? 32'h0 : mode == RUNNING ? (exc ? vec : epc) : pendPC;
    return {en[0], en[1], clr[1], en[2], clr[2], en[3], clr[3], en[4], clr[4], fl, busy, pc};
  endfunction

  task automatic drive(input logic i, input logic d, input logic l, input logic m, input logic x, input logic r);
    {iSt, dSt, lu, md, exc, eret} = {i, d, l, m, x, r};
    #1;
  endtask

  task automatic tick();
    logic [42:0] e;
    logic ev;
    e = expOut();
    ev = exc || eret;
    @(posedge clk);
    if (!rstn) begin
      mode = RUNNING;
      mdDone = 0;
      pendPC = 0;
    end else begin
      if (mode == RUNNING && ev) pendPC = exc ? vec : epc;
      if (e[33] || (e[37] && !e[32])) mdDone = 0;
      else if (e[32] && !dSt) mdDone++;
      mode = e[33] ? (iSt ? REDIRECTING : RUNNING) : (mode == RUNNING && ev) ? DRAINING : mode;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 1, 0, 0);
    total++;
    if (outs !== 43'h0) begin bad++; $display("FAIL reset_hold got=%h want=0", outs); end
    tick();
    rstn = 1;
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (outs[42:32] !== 11'h6A8 || RedirectPC !== 32'h0) begin bad++; $display("FAIL reset_release got=%h want=6a8/0", outs); end
    tick();
    drive(0, 1, 0, 1, 0, 0);
    tick();
    drive(0, 1, 0, 1, 0, 0);
    #2 rstn = 0;
    #1;
    total++;
    if (outs !== 43'h0) begin bad++; $display("FAIL reset_async got=%h want=0", outs); end
    tick();
    rstn = 1;
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (outs !== expOut() || outs[42:32] !== 11'h6A8) begin bad++; $display("FAIL reset_rerelease got=%h want=%h", outs, expOut()); end
    tick();
  endtask

  task automatic test_load_use();
    drive(0, 0, 1, 0, 0, 0);
    total++;
    if ({PCEn, IF2IDEn, ID2EXClr, EX2MEMEn, MEM2WBEn} !== 5'b00111 || outs !== expOut())
      begin bad++; $display("FAIL load_use got=%h want=%h", outs, expOut()); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (outs[42:32] !== 11'h6A8) begin bad++; $display("FAIL load_use_after got=%h want=6a8", outs[42:32]); end
    tick();
  endtask

  task automatic test_muldiv();
    logic [5:0] busyPat, clrPat;
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 1, 0, 0);
      busyPat[c] = MulDivBusy;
      clrPat[c] = EX2MEMClr;
      total++;
      if (outs !== expOut()) begin bad++; $display("FAIL muldiv_model c=%0d got=%h want=%h", c, outs, expOut()); end
      if (c == 3) begin
        total++;
        if (EX2MEMEn !== 1'b1) begin bad++; $display("FAIL muldiv_advance got=%b want=1", EX2MEMEn); end
      end
      tick();
    end
    total++;
    if (busyPat[3:0] !== 4'b0111 || clrPat[3:0] !== 4'b0111)
      begin bad++; $display("FAIL muldiv_busy4 got=%b/%b want=0111", busyPat[3:0], clrPat[3:0]); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 6; c++) begin
      drive(0, c == 1 || c == 2, 0, 1, 0, 0);
      busyPat[c] = MulDivBusy;
      total++;
      if (outs !== expOut()) begin bad++; $display("FAIL muldiv_dstall_model c=%0d got=%h want=%h", c, outs, expOut()); end
      tick();
    end
    total++;
    if (busyPat !== 6'b011111) begin bad++; $display("FAIL muldiv_busy_dstall got=%b want=011111", busyPat); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_dstall_priority();
    drive(1, 1, 1, 0, 0, 0);
    total++;
    if ({MEM2WBClr, ID2EXClr, MEM2WBEn, EX2MEMEn} !== 4'b1010 || outs !== expOut())
      begin bad++; $display("FAIL dstall_prio got=%h want=%h", outs, expOut()); end
    tick();
  endtask

  task automatic test_exception();
    vec = 32'hBFC00380;
    drive(0, 0, 0, 0, 1, 0);
    total++;
    if ({IF2IDClr, ID2EXClr, EX2MEMClr, MEM2WBClr, RedirectValid, PCEn} !== 6'b111111 || RedirectPC !== 32'hBFC00380)
      begin bad++; $display("FAIL exc_flush got=%h want=clr/bfc00380", outs); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (outs[42:32] !== 11'h6A8 || RedirectPC !== 32'h0) begin bad++; $display("FAIL exc_after got=%h want=6a8/0", outs); end
    tick();
  endtask

  task automatic test_eret_drain();
    epc = 32'h80001000;
    vec = 32'h12345678;
    for (int c = 0; c < 7; c++) begin
      drive(c == 3 || c == 4, c < 3, 0, 0, c == 1, c == 0);
      total++;
      if (c < 3 && outs !== 43'h0) begin bad++; $display("FAIL eret_frozen c=%0d got=%h want=0", c, outs); end
      else if (c >= 3 && c < 6 && (RedirectValid !== 1'b1 || RedirectPC !== 32'h80001000 || PCEn !== 1'b1))
        begin bad++; $display("FAIL eret_redirect c=%0d got=%b/%h want=1/80001000", c, RedirectValid, RedirectPC); end
      else if (c == 6 && outs[42:32] !== 11'h6A8) begin bad++; $display("FAIL eret_run got=%h want=6a8", outs[42:32]); end
      tick();
    end
  endtask

  task automatic test_reset_mid_drain();
    vec = 32'hBFC00380;
    drive(0, 1, 0, 0, 1, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    #2 rstn = 0;
    #1;
    total++;
    if (outs !== 43'h0) begin bad++; $display("FAIL drain_reset got=%h want=0", outs); end
    tick();
    rstn = 1;
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 0, 0, 0, 0);
      total++;
      if (RedirectValid !== 1'b0 || outs[42:32] !== 11'h6A8) begin bad++; $display("FAIL drain_abort c=%0d got=%h want=6a8", c, outs); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      vec = $urandom;
      epc = $urandom;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      total++;
      if (outs !== expOut()) begin bad++; $display("FAIL random n=%0d got=%h want=%h", n, outs, expOut()); end
      tick();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_load_use();
    test_muldiv();
    test_dstall_priority();
    test_exception();
    test_eret_drain();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
